nn_param_loader: RTL and testbench

//  Writer side of the neural_network parameter interface. Accepts one 32-bit word stream (valid/ready) and

---
 rtl/nn_pkg.sv | 38 +++
 rtl/nn_idx_counter.sv | 53 +++++
 rtl/nn_param_loader.sv | 187 ++++++++++++++++++
 tb/tb_nn_param_loader.sv | 245 ++++++++++++++++++++++++
 4 files changed

// File: rtl/nn_pkg.sv
// Shared state encoding and sizing helpers for the neural-network parameter loader.
// NN_LOADER_CHECKSUM_EN inserts the CHK trailer state into the section sequence.
package nn_pkg;

  localparam int NN_WORD_W = 32;

  typedef enum logic [2:0] {IDLE, L1_W, L1_B, L2_W, L2_B, CHK, DONE} loader_state_e;

  function automatic int nn_max(input int a, input int b);
    return (a > b) ? a : b;
  endfunction

  function automatic int nn_l2_bias_words(input int l2_b_bits, input int word_w);
    return l2_b_bits / word_w;
  endfunction

  function automatic int nn_total_words(input int l1_w, input int l1_num, input int l2_w,
                                        input int l2_num, input int l2_b_bits, input int word_w);
`ifdef NN_LOADER_CHECKSUM_EN
    return l1_num * l1_w + l1_num + l2_num * l2_w + l2_num * (l2_b_bits / word_w) + 1;
`else
    return l1_num * l1_w + l1_num + l2_num * l2_w + l2_num * (l2_b_bits / word_w);
`endif
  endfunction

  function automatic loader_state_e nn_next_section(input loader_state_e s);
    case (s)
      L1_W:    return L1_B;
      L1_B:    return L2_W;
      L2_W:    return L2_B;
`ifdef NN_LOADER_CHECKSUM_EN
      L2_B:    return CHK;
`endif
      default: return DONE;
    endcase
  endfunction

endpackage

// File: rtl/nn_idx_counter.sv
// Row/column position counter for one loader section; the column wraps into the row and
// the whole counter wraps to zero after the final position so the next section starts clean.
module nn_idx_counter #(
  parameter int CNT_W = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             clear,
  input  logic             inc,
  input  logic [CNT_W-1:0] row_lim,
  input  logic [CNT_W-1:0] col_lim,
  output logic [CNT_W-1:0] row,
  output logic [CNT_W-1:0] col,
  output logic             last_col,
  output logic             last
);

  logic [CNT_W-1:0] row_q, row_d;
  logic [CNT_W-1:0] col_q, col_d;

  // last marks the final row; together with last_col it identifies the section's final word
  assign last_col = (col_q == col_lim - CNT_W'(1));
  assign last     = (row_q == row_lim - CNT_W'(1));
  assign row      = row_q;
  assign col      = col_q;

  always_comb begin
    row_d = row_q;
    col_d = col_q;
    if (clear) begin
      row_d = '0;
      col_d = '0;
    end else if (inc) begin
      if (last_col) begin
        col_d = '0;
        row_d = last ? '0 : row_q + CNT_W'(1);
      end else begin
        col_d = col_q + CNT_W'(1);
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      row_q <= '0;
      col_q <= '0;
    end else begin
      row_q <= row_d;
      col_q <= col_d;
    end
  end

endmodule

// File: rtl/nn_param_loader.sv
// Deserializes a valid/ready word stream into the layer-1/layer-2 weight and bias arrays.
// Define NN_LOADER_CHECKSUM_EN to require a trailing checksum word (sum of data words mod 2^WORD_W).
module nn_param_loader
  import nn_pkg::*;
#(
  parameter int WORD_W        = NN_WORD_W,
  parameter int L1_NEURON_W   = 824,
  parameter int L1_NEURON_NUM = 10,
  parameter int L2_NEURON_W   = 50,
  parameter int L2_NEURON_NUM = 10,
  parameter int L2_B_BITS     = 64
) (
  input  logic                        clk,
  input  logic                        rst_n,
  input  logic                        start,
  input  logic [WORD_W-1:0]           s_data,
  input  logic                        s_valid,
  output logic                        s_ready,
  output logic signed [WORD_W-1:0]    weight_layer1 [L1_NEURON_NUM][L1_NEURON_W],
  output logic signed [WORD_W-1:0]    bias_layer1   [L1_NEURON_NUM],
  output logic signed [WORD_W-1:0]    weight_layer2 [L2_NEURON_NUM][L2_NEURON_W],
  output logic signed [L2_B_BITS-1:0] bias_layer2   [L2_NEURON_NUM],
  output logic                        busy,
  output logic                        params_valid,
  output logic                        load_err
);

  localparam int B2_WORDS = nn_l2_bias_words(L2_B_BITS, WORD_W);
  localparam int CNT_MAX  = nn_max(nn_max(nn_max(L1_NEURON_W, L1_NEURON_NUM),
                                          nn_max(L2_NEURON_W, L2_NEURON_NUM)), B2_WORDS);
  localparam int CNT_W    = $clog2(CNT_MAX + 1);

  if (L2_B_BITS % WORD_W != 0) begin : g_bad_l2_bias_width
    $error("L2_B_BITS must be an integer multiple of WORD_W");
  end

  loader_state_e state_q, state_d;
  logic          active_q, active_d;
  logic          pv_q, pv_d;
  logic          accept, section_end;
  logic          cnt_clr, cnt_inc, cnt_last_col, cnt_last;
  logic [CNT_W-1:0] row_lim, col_lim, row, col;

  logic signed [WORD_W-1:0]    w1_q [L1_NEURON_NUM][L1_NEURON_W];
  logic signed [WORD_W-1:0]    b1_q [L1_NEURON_NUM];
  logic signed [WORD_W-1:0]    w2_q [L2_NEURON_NUM][L2_NEURON_W];
  logic signed [L2_B_BITS-1:0] b2_q [L2_NEURON_NUM];

`ifdef NN_LOADER_CHECKSUM_EN
  logic              err_q, err_d;
  logic [WORD_W-1:0] sum_q, sum_d;
  assign load_err = err_q;
`else
  assign load_err = 1'b0;
`endif

  assign accept        = s_valid && active_q;
  assign section_end   = accept && cnt_last_col && cnt_last;
  assign s_ready       = active_q;
  assign busy          = active_q;
  assign params_valid  = pv_q;
  assign weight_layer1 = w1_q;
  assign bias_layer1   = b1_q;
  assign weight_layer2 = w2_q;
  assign bias_layer2   = b2_q;

  nn_idx_counter #(.CNT_W(CNT_W)) u_idx (
    .clk      (clk),
    .rst_n    (rst_n),
    .clear    (cnt_clr),
    .inc      (cnt_inc),
    .row_lim  (row_lim),
    .col_lim  (col_lim),
    .row      (row),
    .col      (col),
    .last_col (cnt_last_col),
    .last     (cnt_last)
  );

  // Biases are walked as one column per neuron, except L2 where columns are the bias sub-words
  always_comb begin
    row_lim = CNT_W'(1);
    col_lim = CNT_W'(1);
    case (state_q)
      L1_W: begin row_lim = CNT_W'(L1_NEURON_NUM); col_lim = CNT_W'(L1_NEURON_W); end
      L1_B: begin row_lim = CNT_W'(L1_NEURON_NUM); end
      L2_W: begin row_lim = CNT_W'(L2_NEURON_NUM); col_lim = CNT_W'(L2_NEURON_W); end
      L2_B: begin row_lim = CNT_W'(L2_NEURON_NUM); col_lim = CNT_W'(B2_WORDS); end
      default: ;
    endcase
  end

  always_comb begin
    state_d = state_q;
    pv_d    = pv_q;
    cnt_clr = 1'b0;
    cnt_inc = 1'b0;
`ifdef NN_LOADER_CHECKSUM_EN
    err_d   = err_q;
    sum_d   = sum_q;
`endif
    case (state_q)
      IDLE, DONE: begin
        if (start) begin
          state_d = L1_W;
          pv_d    = 1'b0;
          cnt_clr = 1'b1;
`ifdef NN_LOADER_CHECKSUM_EN
          err_d   = 1'b0;
          sum_d   = '0;
`endif
        end
      end
      L1_W, L1_B, L2_W, L2_B: begin
        if (accept) begin
          cnt_inc = 1'b1;
`ifdef NN_LOADER_CHECKSUM_EN
          sum_d   = sum_q + s_data;
`endif
          if (section_end) begin
            state_d = nn_next_section(state_q);
            pv_d    = (state_d == DONE);
          end
        end
      end
`ifdef NN_LOADER_CHECKSUM_EN
      CHK: begin
        if (accept) begin
          state_d = DONE;
          pv_d    = (s_data == sum_q);
          err_d   = (s_data != sum_q);
        end
      end
`endif
      default: state_d = IDLE;
    endcase
    active_d = (state_d != IDLE) && (state_d != DONE);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= IDLE;
      active_q <= 1'b0;
      pv_q     <= 1'b0;
`ifdef NN_LOADER_CHECKSUM_EN
      err_q    <= 1'b0;
      sum_q    <= '0;
`endif
    end else begin
      state_q  <= state_d;
      active_q <= active_d;
      pv_q     <= pv_d;
`ifdef NN_LOADER_CHECKSUM_EN
      err_q    <= err_d;
      sum_q    <= sum_d;
`endif
    end
  end

  // Each accepted word lands in the element addressed by the section counter; L2 biases fill sub-word by sub-word
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int n = 0; n < L1_NEURON_NUM; n++) begin
        b1_q[n] <= '0;
        for (int i = 0; i < L1_NEURON_W; i++) w1_q[n][i] <= '0;
      end
      for (int n = 0; n < L2_NEURON_NUM; n++) begin
        b2_q[n] <= '0;
        for (int i = 0; i < L2_NEURON_W; i++) w2_q[n][i] <= '0;
      end
    end else if (accept) begin
      for (int n = 0; n < L1_NEURON_NUM; n++) begin
        if (state_q == L1_B && row == CNT_W'(n)) b1_q[n] <= s_data;
        for (int i = 0; i < L1_NEURON_W; i++)
          if (state_q == L1_W && row == CNT_W'(n) && col == CNT_W'(i)) w1_q[n][i] <= s_data;
      end
      for (int n = 0; n < L2_NEURON_NUM; n++) begin
        for (int i = 0; i < L2_NEURON_W; i++)
          if (state_q == L2_W && row == CNT_W'(n) && col == CNT_W'(i)) w2_q[n][i] <= s_data;
        for (int k = 0; k < B2_WORDS; k++)
          if (state_q == L2_B && row == CNT_W'(n) && col == CNT_W'(k))
            b2_q[n][k*WORD_W +: WORD_W] <= s_data;
      end
    end
  end

endmodule

// File: tb/tb_nn_param_loader.sv
// Directed bench for nn_param_loader with a small 4x2 / 3x2 network (20 data words per load).
module tb_nn_param_loader;

  localparam int L1W = 4;
  localparam int L1N = 2;
  localparam int L2W = 3;
  localparam int L2N = 2;
  localparam int B2B = 64;
  localparam int NUM_WORDS = 20;
`ifdef NN_LOADER_CHECKSUM_EN
  localparam int TRAILER = 1;
`else
  localparam int TRAILER = 0;
`endif

  logic        clk = 1'b0;
  logic        rst_n = 1'b1;
  logic        start = 1'b0;
  logic [31:0] s_data = '0;
  logic        s_valid = 1'b0;
  logic        s_ready;
  logic signed [31:0]    weight_layer1 [L1N][L1W];
  logic signed [31:0]    bias_layer1   [L1N];
  logic signed [31:0]    weight_layer2 [L2N][L2W];
  logic signed [B2B-1:0] bias_layer2   [L2N];
  logic        busy;
  logic        params_valid;
  logic        load_err;

  int          testCount = 0;
  int          failCount = 0;
  int          cyc = 0;
  int          loadStartCyc = 0;
  logic [31:0] words [NUM_WORDS];

  nn_param_loader #(
    .WORD_W(32), .L1_NEURON_W(L1W), .L1_NEURON_NUM(L1N),
    .L2_NEURON_W(L2W), .L2_NEURON_NUM(L2N), .L2_B_BITS(B2B)
  ) dut (
    .clk           (clk),
    .rst_n         (rst_n),
    .start         (start),
    .s_data        (s_data),
    .s_valid       (s_valid),
    .s_ready       (s_ready),
    .weight_layer1 (weight_layer1),
    .bias_layer1   (bias_layer1),
    .weight_layer2 (weight_layer2),
    .bias_layer2   (bias_layer2),
    .busy          (busy),
    .params_valid  (params_valid),
    .load_err      (load_err)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc++;

  initial begin
    #400000;
    $display("[TB] FAIL watchdog: simulation did not finish");
    $fatal(1, "[TB] watchdog expired");
  end

  task automatic checkOutput(input string tag, input logic [63:0] observed, input logic [63:0] expected);
    testCount++;
    assert (observed === expected)
    else begin
      failCount++;
      $error("[TB] FAIL %s observed=%h expected=%h", tag, observed, expected);
    end
  endtask

  // Offers one word, optionally after an idle gap, and waits a bounded time for acceptance
  task automatic applyStimulus(input logic [31:0] w, input int gapPct);
    bit accepted;
    int guard;
    if (gapPct > 0 && $urandom_range(0, 99) < gapPct) begin
      s_valid = 1'b0;
      @(posedge clk); #1;
    end
    s_data   = w;
    s_valid  = 1'b1;
    accepted = 1'b0;
    guard    = 0;
    while (!accepted && guard < 20) begin
      accepted = s_ready;
      @(posedge clk); #1;
      guard++;
    end
    s_valid = 1'b0;
    checkOutput("word_accepted", {63'd0, accepted}, 64'd1);
  endtask

  task automatic pulseStart();
    start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    loadStartCyc = cyc;
  endtask

  task automatic runLoad(input int gapPct, input int trailerDelta);
    logic [31:0] sum;
    sum = '0;
    pulseStart();
    checkOutput("pv_cleared_on_start", {63'd0, params_valid}, 64'd0);
    checkOutput("busy_after_start", {63'd0, busy}, 64'd1);
    for (int k = 0; k < NUM_WORDS; k++) begin
      if (k == NUM_WORDS - 1) checkOutput("pv_before_last", {63'd0, params_valid}, 64'd0);
      applyStimulus(words[k], gapPct);
      sum = sum + words[k];
    end
`ifdef NN_LOADER_CHECKSUM_EN
    checkOutput("pv_before_trailer", {63'd0, params_valid}, 64'd0);
    applyStimulus(sum + 32'(trailerDelta), gapPct);
`endif
  endtask

  task automatic checkAll(input string tag);
    for (int n = 0; n < L1N; n++) begin
      for (int i = 0; i < L1W; i++)
        checkOutput($sformatf("%s_w1[%0d][%0d]", tag, n, i),
                    {32'd0, weight_layer1[n][i]}, {32'd0, words[n*L1W+i]});
      checkOutput($sformatf("%s_b1[%0d]", tag, n), {32'd0, bias_layer1[n]}, {32'd0, words[L1N*L1W+n]});
    end
    for (int n = 0; n < L2N; n++) begin
      for (int i = 0; i < L2W; i++)
        checkOutput($sformatf("%s_w2[%0d][%0d]", tag, n, i),
                    {32'd0, weight_layer2[n][i]}, {32'd0, words[10+n*L2W+i]});
      checkOutput($sformatf("%s_b2[%0d]", tag, n), bias_layer2[n], {words[17+2*n], words[16+2*n]});
    end
  endtask

  initial begin
    #2 rst_n = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    checkOutput("rst_s_ready", {63'd0, s_ready}, 64'd0);
    checkOutput("rst_busy", {63'd0, busy}, 64'd0);
    checkOutput("rst_pv", {63'd0, params_valid}, 64'd0);
    checkOutput("rst_err", {63'd0, load_err}, 64'd0);
    checkOutput("rst_w1", {32'd0, weight_layer1[0][0]}, 64'd0);
    checkOutput("rst_b2", bias_layer2[1], 64'd0);
    rst_n = 1'b1;
    @(posedge clk); #1;
    checkOutput("idle_s_ready", {63'd0, s_ready}, 64'd0);

    $display("[TB] test 1: back-to-back load of words 1..20");
    for (int k = 0; k < NUM_WORDS; k++) words[k] = 32'(k + 1);
    runLoad(0, 0);
    checkOutput("t1_latency", 64'(cyc - loadStartCyc), 64'(NUM_WORDS + TRAILER));
    checkOutput("t1_pv", {63'd0, params_valid}, 64'd1);
    checkOutput("t1_busy", {63'd0, busy}, 64'd0);
    checkOutput("t1_err", {63'd0, load_err}, 64'd0);
    checkOutput("t1_w1_1_0", {32'd0, weight_layer1[1][0]}, 64'd5);
    checkOutput("t1_b1_0", {32'd0, bias_layer1[0]}, 64'd9);
    checkOutput("t1_b1_1", {32'd0, bias_layer1[1]}, 64'd10);
    checkOutput("t1_w2_0_2", {32'd0, weight_layer2[0][2]}, 64'd13);
    checkOutput("t1_b2_0", bias_layer2[0], 64'h00000012_00000011);
    s_data  = 32'hDEAD_BEEF;
    s_valid = 1'b1;
    for (int c = 0; c < 3; c++) begin
      @(posedge clk); #1;
      checkOutput("done_s_ready", {63'd0, s_ready}, 64'd0);
    end
    s_valid = 1'b0;
    checkAll("t1");

    $display("[TB] test 2: same data with random valid gaps");
    rst_n = 1'b0;
    #2;
    rst_n = 1'b1;
    @(posedge clk); #1;
    runLoad(30, 0);
    checkOutput("t2_pv", {63'd0, params_valid}, 64'd1);
    checkAll("t2");
    repeat (2) @(posedge clk);
    #1;
    checkOutput("t2_done_s_ready", {63'd0, s_ready}, 64'd0);

    $display("[TB] test 3: start ignored while busy, then reset mid-load");
    pulseStart();
    for (int k = 1; k <= 6; k++) applyStimulus(32'(k), 0);
    start = 1'b1;
    applyStimulus(32'd7, 0);
    start = 1'b0;
    for (int k = 8; k <= 11; k++) applyStimulus(32'(k), 0);
    checkOutput("t3_w1_0_0", {32'd0, weight_layer1[0][0]}, 64'd1);
    checkOutput("t3_w1_1_2", {32'd0, weight_layer1[1][2]}, 64'd7);
    checkOutput("t3_w1_1_3", {32'd0, weight_layer1[1][3]}, 64'd8);
    checkOutput("t3_b1_0", {32'd0, bias_layer1[0]}, 64'd9);
    checkOutput("t3_busy", {63'd0, busy}, 64'd1);
    s_data  = 32'd12;
    s_valid = 1'b1;
    #2 rst_n = 1'b0;
    #1;
    checkOutput("t3_rst_w1_0_0", {32'd0, weight_layer1[0][0]}, 64'd0);
    checkOutput("t3_rst_w1_1_2", {32'd0, weight_layer1[1][2]}, 64'd0);
    checkOutput("t3_rst_b1_1", {32'd0, bias_layer1[1]}, 64'd0);
    checkOutput("t3_rst_w2_0_0", {32'd0, weight_layer2[0][0]}, 64'd0);
    checkOutput("t3_rst_b2_0", bias_layer2[0], 64'd0);
    checkOutput("t3_rst_busy", {63'd0, busy}, 64'd0);
    checkOutput("t3_rst_pv", {63'd0, params_valid}, 64'd0);
    checkOutput("t3_rst_s_ready", {63'd0, s_ready}, 64'd0);
    s_valid = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk); #1;
    checkOutput("t3_idle_s_ready", {63'd0, s_ready}, 64'd0);

    $display("[TB] test 4: reload over a complete set");
    runLoad(0, 0);
    checkOutput("t4_first_pv", {63'd0, params_valid}, 64'd1);
    for (int k = 0; k < NUM_WORDS; k++) words[k] = 32'(101 + k);
    runLoad(0, 0);
    checkOutput("t4_pv", {63'd0, params_valid}, 64'd1);
    checkOutput("t4_w1_0_0", {32'd0, weight_layer1[0][0]}, 64'd101);
    checkAll("t4");

    $display("[TB] test 5: negative weight and bias values");
    for (int k = 0; k < NUM_WORDS; k++) words[k] = 32'(k + 1);
    words[0]  = 32'hFFFF_FFFF;
    words[16] = 32'hFFFF_FFFE;
    words[17] = 32'hFFFF_FFFF;
    runLoad(0, 0);
    checkOutput("t5_neg_weight", $signed(weight_layer1[0][0]), -1);
    checkOutput("t5_neg_bias", bias_layer2[0], -2);
    checkAll("t5");

`ifdef NN_LOADER_CHECKSUM_EN
    $display("[TB] test 6: checksum trailer good and bad");
    for (int k = 0; k < NUM_WORDS; k++) words[k] = 32'(k + 1);
    runLoad(0, 1);
    checkOutput("t6_bad_err", {63'd0, load_err}, 64'd1);
    checkOutput("t6_bad_pv", {63'd0, params_valid}, 64'd0);
    checkOutput("t6_bad_busy", {63'd0, busy}, 64'd0);
    runLoad(0, 0);
    checkOutput("t6_good_err", {63'd0, load_err}, 64'd0);
    checkOutput("t6_good_pv", {63'd0, params_valid}, 64'd1);
`endif

    $display("[TB] %0d tests run, %0d failed", testCount, failCount);
    $finish;
  end

endmodule
